// File: rtl/fc_pkg.sv
// Shared types and helpers for streaming fully-connected layers.
// Provides the layer FSM encoding and the requantisation helper.
package fc_pkg;

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_FIN = 2'd1,
    S_OUT = 2'd2
  } fc_state_e;

  function automatic int fc_beats(input int in_size, input int lanes);
    return in_size / lanes;
  endfunction

  function automatic int fc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Floor shift, then clamp to the signed out_w range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input int                 frac,
    input int                 out_w
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/fc_layer_stream_requant.sv
// Per-neuron bias add, floor shift, saturation and optional ReLU.
// Purely combinational; the bias add wraps at ACC_WIDTH.
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int FRAC_BITS = 8,
  parameter int OUT_WIDTH = 16,
  parameter int RELU      = 1
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [ACC_WIDTH-1:0] bias,
  output logic signed [OUT_WIDTH-1:0] res
);

  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [63:0]          q;

  always_comb begin
    sum = acc + bias;
    q   = sat_shift(64'(sum), FRAC_BITS, OUT_WIDTH);
    if (RELU != 0 && q < 0) q = '0;
    res = OUT_WIDTH'(q);
  end

endmodule

// File: rtl/fc_layer_stream.sv
// Multi-lane streaming FC layer: parallel MAC over input beats,
// then requantised results serialised one neuron per beat.
module fc_layer_stream
  import fc_pkg::*;
#(
  parameter int NUM_NEURONS  = 16,
  parameter int INPUT_SIZE   = 16,
  parameter int LANES        = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int FRAC_BITS    = 8,
  parameter int OUT_WIDTH    = 16,
  parameter int RELU         = 1,
  localparam int BEATS = fc_beats(INPUT_SIZE, LANES),
  localparam int AW    = fc_aw(BEATS),
  localparam int IW    = fc_aw(NUM_NEURONS)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]               in_data,
  output logic [AW-1:0]                             weight_addr,
  input  logic [LANES*NUM_NEURONS*WEIGHT_WIDTH-1:0] weight_row,
  input  logic [NUM_NEURONS*ACC_WIDTH-1:0]          bias_row,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [OUT_WIDTH-1:0]               out_data,
  output logic [IW-1:0]                             out_idx,
  output logic                                      out_last
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  fc_state_e                   state;
  logic [AW-1:0]               beat;
  logic [IW-1:0]               idx;
  logic signed [ACC_WIDTH-1:0] acc [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0] dot [NUM_NEURONS];
  logic signed [OUT_WIDTH-1:0] rq  [NUM_NEURONS];
  logic signed [OUT_WIDTH-1:0] res [NUM_NEURONS];

  logic beat_last;
  logic idx_last;

  assign beat_last = (beat == AW'(BEATS - 1));
  assign idx_last  = (idx == IW'(NUM_NEURONS - 1));

  // Sum of this beat's lane products for every neuron.
  always_comb begin
    logic signed [PW-1:0] p;
    p = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      dot[n] = '0;
      for (int l = 0; l < LANES; l++) begin
        p = $signed(in_data[l*DATA_WIDTH +: DATA_WIDTH]) *
            $signed(weight_row[(l*NUM_NEURONS+n)*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        dot[n] = dot[n] + ACC_WIDTH'(p);
      end
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_rq
    fc_requant #(
      .ACC_WIDTH(ACC_WIDTH),
      .FRAC_BITS(FRAC_BITS),
      .OUT_WIDTH(OUT_WIDTH),
      .RELU     (RELU)
    ) u_rq (
      .acc (acc[g]),
      .bias($signed(bias_row[g*ACC_WIDTH +: ACC_WIDTH])),
      .res (rq[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ACC;
      beat  <= '0;
      idx   <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        acc[n] <= '0;
        res[n] <= '0;
      end
    end else begin
      unique case (state)
        S_ACC: begin
          if (in_valid) begin
            for (int n = 0; n < NUM_NEURONS; n++)
              acc[n] <= acc[n] + dot[n];
            if (beat_last) begin
              beat  <= '0;
              state <= S_FIN;
            end else begin
              beat <= beat + AW'(1);
            end
          end
        end
        S_FIN: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            res[n] <= rq[n];
            acc[n] <= '0;
          end
          idx   <= '0;
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (idx_last) begin
              idx   <= '0;
              state <= S_ACC;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

  assign in_ready    = !rst && (state == S_ACC);
  assign weight_addr = beat;
  assign out_valid   = (state == S_OUT);
  assign out_data    = (state == S_OUT) ? res[idx] : '0;
  assign out_idx     = idx;
  assign out_last    = (state == S_OUT) && idx_last;

endmodule
